// File: rtl/seven_seg_time_encoder_if.sv
// Timer-field inputs and the four active-low digit outputs of the seven-segment encoder.
// The master drives the binary fields and mode; the slave returns registered segment patterns.
interface seven_seg_time_encoder_if;
  logic [7:0] lsb_binary;
  logic [7:0] msb_binary;
  logic       mode_sel;
  logic [2:0] time_control;
  logic [6:0] hex_msb_h;
  logic [6:0] hex_msb_l;
  logic [6:0] hex_lsb_h;
  logic [6:0] hex_lsb_l;

  modport master (
    output lsb_binary, msb_binary, mode_sel, time_control,
    input  hex_msb_h, hex_msb_l, hex_lsb_h, hex_lsb_l
  );

  modport slave (
    input  lsb_binary, msb_binary, mode_sel, time_control,
    output hex_msb_h, hex_msb_l, hex_lsb_h, hex_lsb_l
  );
endinterface

// File: rtl/seven_seg_time_encoder.sv
// Converts two binary timer fields into four registered active-low 7-segment digits (count-up or countdown).
// Optional SEVSEG_BLANK_LEADING_ZERO_EN blanks a zero tens digit on each field.
module seven_seg_time_encoder (
  input  logic                     clk,
  input  logic                     rst_n,
  seven_seg_time_encoder_if.slave  bus
);

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // digit index: 3 = MSB tens, 2 = MSB units, 1 = LSB tens, 0 = LSB units
  logic [3:0] digit_next [4];
  logic [7:0] msb_sat;
  logic [7:0] lsb_sat;
  logic [3:0] preset;
  logic       in_range;
  logic [3:0] minutes;
  logic [7:0] seconds;

  always_comb begin
    digit_next = '{default: 4'd0};
    msb_sat    = (bus.msb_binary > 8'd99) ? 8'd99 : bus.msb_binary;
    lsb_sat    = (bus.lsb_binary > 8'd99) ? 8'd99 : bus.lsb_binary;
    preset     = {1'b0, bus.time_control} + 4'd1;
    in_range   = (bus.msb_binary != 8'd0) && (bus.msb_binary <= {4'd0, preset})
                 && (bus.lsb_binary <= 8'd59);
    minutes    = 4'd0;
    seconds    = 8'd0;
    if (!bus.mode_sel) begin
      digit_next[3] = 4'(msb_sat / 8'd10);
      digit_next[2] = 4'(msb_sat % 8'd10);
      digit_next[1] = 4'(lsb_sat / 8'd10);
      digit_next[0] = 4'(lsb_sat % 8'd10);
    end else if (in_range) begin
      // Idle, expired and out-of-range inputs fall through to 00:00.
      minutes       = preset - bus.msb_binary[3:0];
      seconds       = 8'd59 - bus.lsb_binary;
      digit_next[2] = minutes;
      digit_next[1] = 4'(seconds / 8'd10);
      digit_next[0] = 4'(seconds % 8'd10);
    end
  end

  logic [6:0] seg_out [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      logic [6:0] seg_next;
      logic [6:0] seg_reg;

`ifdef SEVSEG_BLANK_LEADING_ZERO_EN
      if (gi == 1 || gi == 3) begin : g_tens
        assign seg_next = (digit_next[gi] == 4'd0) ? 7'b1111111 : seg_encode(digit_next[gi]);
      end else begin : g_units
        assign seg_next = seg_encode(digit_next[gi]);
      end
`else
      assign seg_next = seg_encode(digit_next[gi]);
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) seg_reg <= 7'b1111111;
        else        seg_reg <= seg_next;
      end

      assign seg_out[gi] = seg_reg;
    end
  endgenerate

  assign bus.hex_msb_h = seg_out[3];
  assign bus.hex_msb_l = seg_out[2];
  assign bus.hex_lsb_h = seg_out[1];
  assign bus.hex_lsb_l = seg_out[0];

endmodule

// File: tb/tb_seven_seg_time_encoder.sv
// Scoreboard bench for seven_seg_time_encoder: expected digit patterns are queued when inputs are
// driven and compared one clock later.
module tb_seven_seg_time_encoder;

  logic clk;
  logic rst_n;
  int   total_cnt;
  int   bad_cnt;
  logic [27:0] sb_q [$];
  logic [6:0]  seg_tab [10];

  seven_seg_time_encoder_if bus ();

  seven_seg_time_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int d);
    if (d >= 0 && d <= 9) return seg_tab[d];
    return 7'b1111111;
  endfunction

  function automatic logic [6:0] tens_of(input int d);
`ifdef SEVSEG_BLANK_LEADING_ZERO_EN
    if (d == 0) return 7'b1111111;
`endif
    return seg_of(d);
  endfunction

  // Reference model built straight from the display rules: four digits packed {MSBH,MSBL,LSBH,LSBL}.
  function automatic logic [27:0] model(input int m, input int l, input logic ms, input int tc);
    int p, mm, ss;
    if (!ms) begin
      mm = (m > 99) ? 99 : m;
      ss = (l > 99) ? 99 : l;
    end else begin
      p = tc + 1;
      if (m >= 1 && m <= p && l <= 59) begin
        mm = p - m;
        ss = 59 - l;
      end else begin
        mm = 0;
        ss = 0;
      end
    end
    return {tens_of(mm / 10), seg_of(mm % 10), tens_of(ss / 10), seg_of(ss % 10)};
  endfunction

  task automatic check_val(input string tag, input logic [27:0] observed, input logic [27:0] expected);
    total_cnt++;
    if (observed !== expected) begin
      bad_cnt++;
      $display("FAIL %s: got=%h want=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [27:0] outputs_now();
    return {bus.hex_msb_h, bus.hex_msb_l, bus.hex_lsb_h, bus.hex_lsb_l};
  endfunction

  task automatic apply(input string tag, input int m, input int l, input logic ms, input int tc);
    logic [27:0] exp_v;
    @(negedge clk);
    bus.msb_binary   = 8'(m);
    bus.lsb_binary   = 8'(l);
    bus.mode_sel     = ms;
    bus.time_control = 3'(tc);
    sb_q.push_back(model(m, l, ms, tc));
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, outputs_now(), 28'hxxxxxxx);
    end else begin
      exp_v = sb_q.pop_front();
      check_val(tag, outputs_now(), exp_v);
      $display("txn %s msb=%0d lsb=%0d mode=%0d tc=%0d out=%h", tag, m, l, ms, tc, outputs_now());
    end
  endtask

  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    total_cnt = 0;
    bad_cnt   = 0;
    rst_n            = 1'b0;
    bus.msb_binary   = 8'd47;
    bus.lsb_binary   = 8'd8;
    bus.mode_sel     = 1'b0;
    bus.time_control = 3'd2;

    // Reset held across edges with live inputs, then released: still blank until next edge.
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_hold", outputs_now(), {4{7'b1111111}});
    $display("txn rst_hold out=%h", outputs_now());
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("rst_release", outputs_now(), {4{7'b1111111}});
    $display("txn rst_release out=%h", outputs_now());

    apply("first_after_rst", 47, 8, 1'b0, 2);

    // Asynchronous assertion mid-cycle must blank outputs without a clock edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("rst_async", outputs_now(), {4{7'b1111111}});
    $display("txn rst_async out=%h", outputs_now());
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();

    for (int i = 0; i < 100; i++)
      for (int j = 0; j < 100; j++)
        apply("modeA_sweep", i, j, 1'b0, 2);

    apply("modeA_sat", 150, 255, 1'b0, 2);
    apply("modeA_sat_max", 255, 100, 1'b0, 5);

    for (int i = 1; i <= 3; i++)
      for (int j = 0; j < 60; j++)
        apply("modeB_sweep", i, j, 1'b1, 2);

    apply("modeB_idle", 0, 0, 1'b1, 2);
    apply("modeB_idle_lsb", 0, 37, 1'b1, 2);
    apply("modeB_msb_over", 5, 10, 1'b1, 2);
    apply("modeB_msb_p1", 4, 0, 1'b1, 2);
    apply("modeB_lsb_over", 1, 60, 1'b1, 2);
    apply("modeB_preset7", 1, 0, 1'b1, 7);
    apply("modeB_preset7_end", 8, 59, 1'b1, 7);
    apply("modeB_preset0", 1, 30, 1'b1, 0);
    apply("toggle_to_A", 1, 0, 1'b0, 7);
    apply("toggle_to_B", 1, 0, 1'b1, 7);
    apply("toggle_tc", 2, 34, 1'b1, 2);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
